// File: rtl/pair_arbiter_pkg.sv
// Shared types and constants for the pair arbiter.
// Holds the FSM encoding, the filler word and width helpers.
package pair_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    localparam int MAX_DIN_WIDTH = 4096;

    localparam logic [MAX_DIN_WIDTH-1:0] FILL_WORD = '1;

    function automatic int stall_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pair_arbiter_rr_select.sv
// Round-robin requester picker, purely combinational.
// Searches from last+1 upward, wrapping at N_CH-1 back to 0.
module rr_select #(
    parameter int N_CH = 4,
    parameter int CW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   last,
    output logic [N_CH-1:0] grant,
    output logic [CW-1:0]   idx,
    output logic            any
);

    int k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 1; i <= N_CH; i++) begin
            k = (int'(last) + i) % N_CH;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = CW'(k);
            end
        end
    end

endmodule

// File: rtl/pair_arbiter.sv
// Channel arbiter that forwards beats in same-channel pairs,
// padding a stalled pair with an all-ones filler beat.
module pair_arbiter
    import pair_arbiter_pkg::*;
#(
    parameter int DIN_WIDTH   = 128,
    parameter int N_CH        = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      CLK,
    input  logic                      RESETN,
    input  logic [N_CH-1:0]           iVALID,
    output logic [N_CH-1:0]           oREADY,
    input  logic [N_CH*DIN_WIDTH-1:0] DIN,
    input  logic                      iREADY,
    output logic                      oVALID,
    output logic [DIN_WIDTH-1:0]      DOUT,
    output logic [$clog2(N_CH)-1:0]   oCH,
    output logic                      oPAD
);

    localparam int CW = $clog2(N_CH);
    localparam int SW = stall_width(TIMEOUT_CYC);
    localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT_CYC);
    localparam logic [DIN_WIDTH-1:0] FILL = FILL_WORD[DIN_WIDTH-1:0];

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   last_grant;
    logic [CW-1:0]   last_nx;
    logic [CW-1:0]   lock_ch;
    logic [CW-1:0]   lock_nx;
    logic [SW-1:0]   stall_cnt;
    logic [SW-1:0]   stall_nx;

    logic [N_CH-1:0] rr_grant;
    logic [CW-1:0]   rr_idx;
    logic            rr_any;

    logic [N_CH-1:0] ready;
    logic [CW-1:0]   xfer_ch;
    logic            xfer;
    logic            fill;

    logic [DIN_WIDTH-1:0] din_ch [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_slice
        assign din_ch[g] = DIN[g*DIN_WIDTH +: DIN_WIDTH];
    end

    rr_select #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_rr (
        .req   (iVALID),
        .last  (last_grant),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    always_comb begin
        state_nx = state;
        last_nx  = last_grant;
        lock_nx  = lock_ch;
        stall_nx = stall_cnt;
        ready    = '0;
        fill     = 1'b0;
        xfer_ch  = lock_ch;
        unique case (state)
            ST_IDLE: begin
                xfer_ch = rr_idx;
                if (iREADY && rr_any) begin
                    ready    = rr_grant;
                    state_nx = ST_SECOND;
                    lock_nx  = rr_idx;
                    stall_nx = '0;
                end
            end
            ST_SECOND: begin
                // A stalled partner is padded rather than left open forever
                if (iREADY) begin
                    if (stall_cnt == STALL_MAX) begin
                        fill     = 1'b1;
                        state_nx = ST_IDLE;
                        last_nx  = lock_ch;
                        stall_nx = '0;
                    end else begin
                        ready[lock_ch] = 1'b1;
                        if (iVALID[lock_ch]) begin
                            state_nx = ST_IDLE;
                            last_nx  = lock_ch;
                        end else begin
                            stall_nx = stall_cnt + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign xfer   = |(ready & iVALID);
    assign oREADY = ready & {N_CH{RESETN}};

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= ST_IDLE;
            last_grant <= CW'(N_CH - 1);
            lock_ch    <= '0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_nx;
            last_grant <= last_nx;
            lock_ch    <= lock_nx;
            stall_cnt  <= stall_nx;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            oVALID <= 1'b0;
            oPAD   <= 1'b0;
            oCH    <= '0;
            DOUT   <= FILL;
        end else begin
            oVALID <= xfer | fill;
            oPAD   <= fill;
            if (xfer || fill) begin
                oCH  <= xfer_ch;
                DOUT <= fill ? FILL : din_ch[xfer_ch];
            end
        end
    end

endmodule
